// File: rtl/fifo_stream.sv
// rtl/fifo_stream.sv - synchronous first-word-fall-through FIFO with valid/ready streams
//
// Purpose: buffers DATA_WIDTH payloads between a valid/ready producer and a
// valid/ready consumer. It provides an occupancy count, threshold flags and a
// synchronous flush.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset (clears pointers only)
//   flush_i        synchronous discard of all contents
//   s_data_i       write payload
//   s_valid_i      write request
//   s_ready_o      write can be accepted this cycle
//   m_data_o       head payload, zero when m_valid_o is low
//   m_valid_o      head entry valid
//   m_ready_i      consumer takes the head this cycle
//   count_o        occupancy, 0..FIFO_DEPTH
//   full_o         count_o == FIFO_DEPTH
//   empty_o        count_o == 0
//   almost_full_o  count_o >= ALMOST_FULL_THR
//   almost_empty_o count_o <= ALMOST_EMPTY_THR

module fifo_stream #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 32,
  parameter int ALMOST_FULL_THR  = FIFO_DEPTH - 1,
  parameter int ALMOST_EMPTY_THR = 1,
  localparam int ADDR_WIDTH      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH + 1)'(ALMOST_FULL_THR);
  localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THR);

  // The extra MSB on each pointer is the wrap bit that tells full from empty.
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic wr_en;
  logic rd_en;

  // Status comes from the pointers alone, so during a flush cycle it still
  // shows the occupancy that is about to be discarded.
  assign count_o        = wr_ptr_q - rd_ptr_q;
  assign empty_o        = (wr_ptr_q == rd_ptr_q);
  assign full_o         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                          (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign almost_full_o  = (count_o >= AF_THR);
  assign almost_empty_o = (count_o <= AE_THR);

  // Flush masks both handshakes so nothing moves in the cycle it discards.
  assign s_ready_o = !full_o && !flush_i;
  assign m_valid_o = !empty_o && !flush_i;
  assign m_data_o  = m_valid_o ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : '0;

  assign wr_en = s_valid_i && s_ready_o;
  assign rd_en = m_valid_o && m_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_data_i;
  end

endmodule

// File: doc/fifo_stream.md
Name: fifo_stream

Overview:
- Parametrised synchronous FIFO with valid/ready handshakes on both sides.
- Provides first-word-fall-through output, an occupancy count, threshold-programmable almost-full/almost-empty flags and a synchronous flush.
- Next-generation buffering element for AXI channel paths in the interconnect (AW/W/B/AR/R slices, ID/order queues). It supersedes the plain write/read-strobe FIFO.

Parameters:
- DATA_WIDTH, 8, payload width in bits (>=1).
- FIFO_DEPTH, 32, number of entries; power of two, >=2.
- ALMOST_FULL_THR, FIFO_DEPTH-1, almost_full_o asserts when count_o >= this value (1..FIFO_DEPTH).
- ALMOST_EMPTY_THR, 1, almost_empty_o asserts when count_o <= this value (0..FIFO_DEPTH-1).
- Derived (localparam): ADDR_WIDTH = $clog2(FIFO_DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous discard of all contents.
- s_data_i  input  DATA_WIDTH  write payload.
- s_valid_i  input  1  write request.
- s_ready_o  output  1  FIFO can accept a write this cycle.
- m_data_o  output  DATA_WIDTH  head-of-queue payload.
- m_valid_o  output  1  head entry valid.
- m_ready_i  input  1  consumer takes the head this cycle.
- count_o  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- full_o  output  1  count_o == FIFO_DEPTH.
- empty_o  output  1  count_o == 0.
- almost_full_o  output  1  count_o >= ALMOST_FULL_THR.
- almost_empty_o  output  1  count_o <= ALMOST_EMPTY_THR.

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - rst_n is asynchronous, active-low. While rst_n=0, write/read pointers are cleared immediately and kept cleared.
  - Storage array is not reset.
- Reset output values:
  - s_ready_o=1, m_valid_o=0, m_data_o=0.
  - count_o=0, full_o=0, empty_o=1.
  - almost_empty_o=1, almost_full_o=(ALMOST_FULL_THR==0, never true by range)=0.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide; the MSB is the wrap bit.
  - count_o = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
  - Wrap-around is natural binary rollover with no special case.
- Combinational outputs:
  - s_ready_o = !full && !flush_i.
  - m_valid_o = !empty && !flush_i.
  - m_data_o = m_valid_o ? mem[rd_ptr[ADDR_WIDTH-1:0]] : 0. It is gated to zero whenever invalid, so its value is deterministic.
  - All status flags are combinational from the pointers only. They do not depend on s_valid_i, m_ready_i or flush_i.
- Write: a write is accepted when s_valid_i && s_ready_o at the edge. Data is stored at wr_ptr and wr_ptr increments.
- Read: a read is accepted when m_valid_o && m_ready_i at the edge, and rd_ptr increments.
- Latency:
  - A write into an empty FIFO becomes visible on m_valid_o/m_data_o the cycle after acceptance.
  - There is no same-cycle bypass from s_data_i to m_data_o.
- Throughput: one write and one read per cycle sustained.
- Simultaneous read and write:
  - When not empty and not full, both are accepted and count_o is unchanged.
  - When full, only the read is accepted, because s_ready_o=0. count_o decrements, and s_ready_o rises the next cycle.
  - When empty, only the write is accepted, because m_valid_o=0.
- Illegal requests:
  - s_valid_i while full is ignored. No overwrite occurs, and the pointers and data are unchanged.
  - m_ready_i while empty is ignored.
- Flush:
  - flush_i=1 at an edge sets rd_ptr <= wr_ptr, which makes the FIFO empty next cycle.
  - Flush has priority: no write or read is accepted in the flush cycle. The ready/valid outputs are forced low for that cycle.
  - Status flags still reflect pre-flush occupancy during the flush cycle.
- Reset mid-operation: asserting rst_n=0 at any time, including mid-burst, empties the FIFO asynchronously. The first write after deassertion lands at entry 0.
- Handshake compliance:
  - m_data_o stays stable while m_valid_o=1 and m_ready_i=0.
  - m_valid_o never drops without a read or a flush.

Test Plan:
Configuration for all scenarios: DATA_WIDTH=8, FIFO_DEPTH=4, ALMOST_FULL_THR=3, ALMOST_EMPTY_THR=1.
- Reset then single write: write 0xA5 in cycle 0 -> cycle 1 shows m_valid_o=1, m_data_o=0xA5, count_o=1, almost_empty_o=1. Reading in cycle 1 -> cycle 2 shows empty_o=1 and m_data_o=0.
- Fill with 0x11..0x44 and hold s_valid_i=1 with 0x55 -> count_o goes 1,2,3,4; almost_full_o at 3; full_o=1 and s_ready_o=0 at 4; 0x55 is dropped. Draining yields 0x11,0x22,0x33,0x44 in order.
- Full plus simultaneous s_valid_i and m_ready_i -> only the read is accepted, count_o=3, s_ready_o=1 next cycle. The next write is accepted.
- Continuous streaming of 12 words with s_valid_i=m_ready_i=1 -> one word per cycle, count_o holds at 1, pointers wrap twice, and output order equals input order.
- Backpressure: m_ready_i=0 for 5 cycles with m_valid_o=1 -> m_data_o is stable throughout.
- Flush with count_o=3 while s_valid_i=1 and m_ready_i=1 -> no handshake occurs in the flush cycle; the next cycle shows count_o=0 and empty_o=1.
- Async reset asserted mid-cycle -> outputs change immediately to reset values. After release, a write of 0x7E reads back as 0x7E.
